demux_1_4_stream: RTL
=====================

// Module: demux_1_4_stream
//
// PURPOSE
//   1:4 stream demultiplexer: the routing counterpart of the 4:1 mux. A single
//   valid/ready input stream carries a WIDTH-bit word and a 2-bit destination
//   select. Each accepted word is steered into one of four independent
//   one-entry output registers, and each register has its own valid/ready
//   handshake. A stalled channel never blocks traffic bound for the others.
//
// PARAMETERS
//   WIDTH  4  data word width in bits
//   CNT_W  8  width of the accepted-transfer counter (wraps modulo 2**CNT_W)
//
// PORTS
//   clk        in   1        clock; all state changes on the rising edge
//   rst        in   1        asynchronous reset, active-high
//   in_valid   in   1        input word valid
//   in_ready   out  1        input can accept (combinational)
//   in_data    in   WIDTH    input word
//   in_sel     in   2        destination channel 0..3; meaningful only when in_valid=1
//   out_valid  out  4        bit k: channel k holds a word
//   out_ready  in   4        bit k: consumer k takes the word this cycle
//   out_d0     out  WIDTH    channel 0 word
//   out_d1     out  WIDTH    channel 1 word
//   out_d2     out  WIDTH    channel 2 word
//   out_d3     out  WIDTH    channel 3 word
//   accept_cnt out  CNT_W    number of accepted input transfers, wrapping
//
// BEHAVIOUR
//   - Reset, asynchronous: out_valid=0, out_d0..out_d3=0, accept_cnt=0. Words
//     buffered when rst asserts are discarded. No transfer occurs while rst=1.
//   - in_ready = ~out_valid[in_sel] | out_ready[in_sel].
//     - It is a function of in_sel and channel state only; it never depends
//       on in_valid.
//   - Accept: in_valid & in_ready at a clock edge.
//     - The channel k=in_sel loads in_data, and out_valid[k] becomes 1.
//     - accept_cnt increments by 1 and wraps from all-ones to 0.
//   - Latency: a word accepted at edge N is visible on out_dk with out_valid[k]=1
//     after edge N. There is no combinational path from in_data to any out_dk.
//   - Pop: out_valid[k] & out_ready[k] at an edge.
//     - If there is no load to channel k on the same edge, out_valid[k] becomes 0.
//     - out_dk keeps its last value; it is not cleared.
//   - Simultaneous pop and load on the same channel: out_valid[k] stays 1 and
//     out_dk takes the new word. This gives full throughput of 1 word per
//     cycle per channel.
//   - Holding: while out_valid[k] & ~out_ready[k], out_dk and out_valid[k] are
//     stable.
//   - Isolation: an accept updates only the selected channel. The other
//     channels' valid and data are unchanged.
//   - in_valid=0: no state change except pops.
//   - Select decode uses one-hot terms from sel[0]/sel[1], as in the mux family.
//
// TESTING
//   1 Reset: assert rst mid-stream while out_valid=4'b1010
//     -> out_valid=0, all out_d*=0 and accept_cnt=0 immediately, before any clock edge.
//   2 Route: out_ready=4'hF; send in_data=4'hA, sel=2
//     -> next cycle out_valid=4'b0100, out_d2=4'hA
//     -> the cycle after, out_valid=0 and accept_cnt=1.
//   3 Backpressure: out_ready[1]=0; send 4'h3 to sel=1, then offer 4'h5 to sel=1
//     -> out_d1=3 held and in_ready=0
//     -> raise out_ready[1]: 4'h5 is accepted on the same edge as the pop,
//        then out_d1=5 with out_valid[1]=1.
//   4 Isolation: channel 1 full and stalled; send 4'h7 to sel=3
//     -> accepted, out_d3=7, out_d1 unchanged.
//   5 Throughput: out_ready[0]=1; stream 4'h1,4'h2,4'h3 to sel=0 on consecutive cycles
//     -> in_ready stays 1, out_valid[0] stays 1, and out_d0 shows 1,2,3
//        on consecutive cycles.
//   6 Wrap: perform 256 accepts with CNT_W=8
//     -> accept_cnt returns to 0; the 257th accept gives 1.

Source files
------------

// File: rtl/demux_1_4_stream_if.sv
// Purpose: bundles the demux input stream, the four output channels and the
//          accepted-transfer counter into one port group.
// Signals:
//   in_valid/in_ready/in_data/in_sel : producer-side stream with 2-bit destination
//   out_valid/out_ready              : per-channel handshake, bit k = channel k
//   out_d0..out_d3                   : channel words
//   accept_cnt                       : wrapping count of accepted input words
// Modports: slave = demux side, master = producer/consumer side.
interface demux_1_4_stream_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_d0;
    logic [WIDTH-1:0] out_d1;
    logic [WIDTH-1:0] out_d2;
    logic [WIDTH-1:0] out_d3;
    logic [CNT_W-1:0] accept_cnt;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_d0, out_d1, out_d2, out_d3, accept_cnt
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_d0, out_d1, out_d2, out_d3, accept_cnt
    );
endinterface

// File: rtl/demux_1_4_stream.sv
// Purpose: 1:4 stream demultiplexer. Each accepted word is steered by in_sel
//          into one of four one-entry output registers, each with its own
//          valid/ready handshake, so a stalled channel never blocks the others.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : demux_1_4_stream_if.slave (input stream, four channels, accept_cnt)
// in_ready is combinational from in_sel and channel state; all other outputs
// come straight from flops.
module demux_1_4_stream #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1_4_stream_if.slave    bus
);
    localparam int unsigned N_CH = 4;

    logic [N_CH-1:0]  valid_q, valid_d;
    logic [WIDTH-1:0] data_q [N_CH];
    logic [WIDTH-1:0] data_d [N_CH];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_CH-1:0]  sel_oh;
    logic [N_CH-1:0]  load;
    logic [N_CH-1:0]  pop;
    logic             in_ready_c;
    logic             accept;

    // One-hot select decode from the individual select bits.
    always_comb begin
        sel_oh    = '0;
        sel_oh[0] = ~bus.in_sel[1] & ~bus.in_sel[0];
        sel_oh[1] = ~bus.in_sel[1] &  bus.in_sel[0];
        sel_oh[2] =  bus.in_sel[1] & ~bus.in_sel[0];
        sel_oh[3] =  bus.in_sel[1] &  bus.in_sel[0];
    end

    // Selected channel can take a word if it is empty or draining this cycle.
    assign in_ready_c = |(sel_oh & (~valid_q | bus.out_ready));
    assign accept     = bus.in_valid & in_ready_c;
    assign load       = sel_oh & {N_CH{accept}};
    assign pop        = valid_q & bus.out_ready;

    // Next state: a load on the same edge as a pop keeps the channel full.
    always_comb begin
        valid_d = (valid_q & ~pop) | load;
        cnt_d   = cnt_q;
        for (int k = 0; k < int'(N_CH); k++) begin
            data_d[k] = data_q[k];
        end
        for (int k = 0; k < int'(N_CH); k++) begin
            if (load[k]) begin
                data_d[k] = bus.in_data;
            end
        end
        if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < int'(N_CH); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < int'(N_CH); k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = valid_q;
    assign bus.out_d0     = data_q[0];
    assign bus.out_d1     = data_q[1];
    assign bus.out_d2     = data_q[2];
    assign bus.out_d3     = data_q[3];
    assign bus.accept_cnt = cnt_q;
endmodule
